tl_resp_queue: RTL and testbench

TL_RESP_QUEUE -- requirements
Module: tl_resp_queue

---
 rtl/tl_resp_queue_if.sv | 32 +++
 rtl/tl_resp_queue.sv | 106 ++++++++++
 tb/tb_tl_resp_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tl_resp_queue_if.sv
// Handshake and payload bundle for tl_resp_queue: an enqueue side and a dequeue side.
// The queue binds to the slave modport; whoever feeds and drains it uses master.
interface tl_resp_queue_if #(
  parameter int OPCODE_W = 3,
  parameter int SIZE_W   = 4,
  parameter int SOURCE_W = 7
);
  logic                io_enq_valid;
  logic                io_enq_ready;
  logic [OPCODE_W-1:0] io_enq_bits_opcode;
  logic [SIZE_W-1:0]   io_enq_bits_size;
  logic [SOURCE_W-1:0] io_enq_bits_source;
  logic                io_deq_valid;
  logic                io_deq_ready;
  logic [OPCODE_W-1:0] io_deq_bits_opcode;
  logic [SIZE_W-1:0]   io_deq_bits_size;
  logic [SOURCE_W-1:0] io_deq_bits_source;

  modport master (
    output io_enq_valid, io_enq_bits_opcode, io_enq_bits_size, io_enq_bits_source,
    output io_deq_ready,
    input  io_enq_ready, io_deq_valid,
    input  io_deq_bits_opcode, io_deq_bits_size, io_deq_bits_source
  );

  modport slave (
    input  io_enq_valid, io_enq_bits_opcode, io_enq_bits_size, io_enq_bits_source,
    input  io_deq_ready,
    output io_enq_ready, io_deq_valid,
    output io_deq_bits_opcode, io_deq_bits_size, io_deq_bits_source
  );
endinterface

// File: rtl/tl_resp_queue.sv
// Circular-buffer response queue (opcode/size/source) with optional pipelined enqueue when full.
// Define TL_RESP_QUEUE_FLOW_EN to let an entry bypass storage when the queue is empty.
module tl_resp_queue #(
  parameter int DEPTH    = 2,
  parameter int OPCODE_W = 3,
  parameter int SIZE_W   = 4,
  parameter int SOURCE_W = 7,
  parameter int PIPE     = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  tl_resp_queue_if.slave   io,
  output logic [CNT_W-1:0] io_count
);

  // A single-entry queue keeps its pointers pinned at 0, so maybe_full alone encodes full.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [OPCODE_W-1:0] mem_opcode [DEPTH];
  logic [SIZE_W-1:0]   mem_size   [DEPTH];
  logic [SOURCE_W-1:0] mem_source [DEPTH];

  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;
  logic [CNT_W-1:0] count;

  logic ptr_match, empty, full;
  logic enq_ready, deq_valid;
  logic do_enq, do_deq, wr_en, rd_en;
  logic [OPCODE_W-1:0] deq_opcode;
  logic [SIZE_W-1:0]   deq_size;
  logic [SOURCE_W-1:0] deq_source;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  always_comb begin
    ptr_match = (enq_ptr == deq_ptr);
    empty     = ptr_match && !maybe_full;
    full      = ptr_match && maybe_full;
    if (PIPE != 0) enq_ready = !full || io.io_deq_ready;
    else           enq_ready = !full;
    do_enq = io.io_enq_valid && enq_ready;
`ifdef TL_RESP_QUEUE_FLOW_EN
    // When empty the head is the incoming entry; if it leaves this cycle it is never stored.
    deq_valid  = !empty || io.io_enq_valid;
    deq_opcode = empty ? io.io_enq_bits_opcode : mem_opcode[deq_ptr];
    deq_size   = empty ? io.io_enq_bits_size   : mem_size[deq_ptr];
    deq_source = empty ? io.io_enq_bits_source : mem_source[deq_ptr];
    do_deq     = deq_valid && io.io_deq_ready;
    wr_en      = do_enq && !(empty && io.io_deq_ready);
    rd_en      = do_deq && !empty;
`else
    deq_valid  = !empty;
    deq_opcode = mem_opcode[deq_ptr];
    deq_size   = mem_size[deq_ptr];
    deq_source = mem_source[deq_ptr];
    do_deq     = deq_valid && io.io_deq_ready;
    wr_en      = do_enq;
    rd_en      = do_deq;
`endif
  end

  assign io.io_enq_ready       = enq_ready;
  assign io.io_deq_valid       = deq_valid;
  assign io.io_deq_bits_opcode = deq_opcode;
  assign io.io_deq_bits_size   = deq_size;
  assign io.io_deq_bits_source = deq_source;
  assign io_count              = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
      count      <= '0;
    end else begin
      if (wr_en) enq_ptr <= next_ptr(enq_ptr);
      if (rd_en) deq_ptr <= next_ptr(deq_ptr);
      if (wr_en != rd_en) begin
        maybe_full <= wr_en;
        count      <= wr_en ? count + CNT_W'(1) : count - CNT_W'(1);
      end
    end
  end

  // Storage is cleared on reset so the head payload reads as zero while empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_opcode[i] <= '0;
        mem_size[i]   <= '0;
        mem_source[i] <= '0;
      end
    end else if (wr_en) begin
      mem_opcode[enq_ptr] <= io.io_enq_bits_opcode;
      mem_size[enq_ptr]   <= io.io_enq_bits_size;
      mem_source[enq_ptr] <= io.io_enq_bits_source;
    end
  end

endmodule

// File: tb/tb_tl_resp_queue.sv
// Directed bench for tl_resp_queue: four instances (DEPTH 4/3/2-pipe/1) checked with immediate assertions.
module tb_tl_resp_queue;

  logic clock;
  logic reset;
  int   n_asserts;
  int   n_fail;

  tl_resp_queue_if q4 ();
  tl_resp_queue_if q3 ();
  tl_resp_queue_if q2 ();
  tl_resp_queue_if q1 ();

  logic [2:0] cnt4;
  logic [1:0] cnt3;
  logic [1:0] cnt2;
  logic [0:0] cnt1;

  tl_resp_queue #(.DEPTH(4), .PIPE(0)) u_q4 (.clock(clock), .reset(reset), .io(q4.slave), .io_count(cnt4));
  tl_resp_queue #(.DEPTH(3), .PIPE(0)) u_q3 (.clock(clock), .reset(reset), .io(q3.slave), .io_count(cnt3));
  tl_resp_queue #(.DEPTH(2), .PIPE(1)) u_q2 (.clock(clock), .reset(reset), .io(q2.slave), .io_count(cnt2));
  tl_resp_queue #(.DEPTH(1), .PIPE(0)) u_q1 (.clock(clock), .reset(reset), .io(q1.slave), .io_count(cnt1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one queue's inputs; sel picks the instance by its depth.
  task automatic applyStimulus(input int sel, input bit ev, input int op, input int sz,
                               input int src, input bit dr);
    case (sel)
      4: begin
        q4.io_enq_valid = ev; q4.io_enq_bits_opcode = 3'(op);
        q4.io_enq_bits_size = 4'(sz); q4.io_enq_bits_source = 7'(src); q4.io_deq_ready = dr;
      end
      3: begin
        q3.io_enq_valid = ev; q3.io_enq_bits_opcode = 3'(op);
        q3.io_enq_bits_size = 4'(sz); q3.io_enq_bits_source = 7'(src); q3.io_deq_ready = dr;
      end
      2: begin
        q2.io_enq_valid = ev; q2.io_enq_bits_opcode = 3'(op);
        q2.io_enq_bits_size = 4'(sz); q2.io_enq_bits_source = 7'(src); q2.io_deq_ready = dr;
      end
      default: begin
        q1.io_enq_valid = ev; q1.io_enq_bits_opcode = 3'(op);
        q1.io_enq_bits_size = 4'(sz); q1.io_enq_bits_source = 7'(src); q1.io_deq_ready = dr;
      end
    endcase
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset     = 1'b0;
    applyStimulus(4, 0, 0, 0, 0, 0);
    applyStimulus(3, 0, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst q4 enq_ready", 32'(q4.io_enq_ready), 1);
    checkOutput("rst q4 deq_valid", 32'(q4.io_deq_valid), 0);
    checkOutput("rst q4 count", 32'(cnt4), 0);
    checkOutput("rst q4 deq_source", 32'(q4.io_deq_bits_source), 0);
    checkOutput("rst q3 count", 32'(cnt3), 0);
    checkOutput("rst q2 enq_ready", 32'(q2.io_enq_ready), 1);
    checkOutput("rst q1 deq_valid", 32'(q1.io_deq_valid), 0);
    @(negedge clock);
    reset = 1'b1;

    // DEPTH=4: fill with sources 1..4, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      applyStimulus(4, 1, i, i + 8, i, 0);
      #1;
      checkOutput("fill q4 enq_ready", 32'(q4.io_enq_ready), 1);
      checkOutput("fill q4 count", 32'(cnt4), 32'(i - 1));
    end
    @(negedge clock);
    applyStimulus(4, 1, 7, 7, 100, 0);
    #1;
    checkOutput("full q4 enq_ready", 32'(q4.io_enq_ready), 0);
    checkOutput("full q4 count", 32'(cnt4), 4);
    checkOutput("full q4 head opcode", 32'(q4.io_deq_bits_opcode), 1);
    checkOutput("full q4 head size", 32'(q4.io_deq_bits_size), 9);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      applyStimulus(4, 0, 0, 0, 0, 1);
      #1;
      checkOutput("drain q4 deq_valid", 32'(q4.io_deq_valid), 1);
      checkOutput("drain q4 source", 32'(q4.io_deq_bits_source), 32'(i));
      checkOutput("drain q4 count", 32'(cnt4), 32'(5 - i));
    end
    @(negedge clock);
    applyStimulus(4, 0, 0, 0, 0, 0);
    #1;
    checkOutput("empty q4 count", 32'(cnt4), 0);
    checkOutput("empty q4 deq_valid", 32'(q4.io_deq_valid), 0);

    // DEPTH=3: preload two, then seven simultaneous enq/deq pairs across the wrap, then drain.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      applyStimulus(3, 1, 0, 0, 20 + i, 0);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      applyStimulus(3, 1, k, 0, 22 + k, 1);
      #1;
      checkOutput("wrap q3 source", 32'(q3.io_deq_bits_source), 32'(20 + k));
      checkOutput("wrap q3 count", 32'(cnt3), 2);
      checkOutput("wrap q3 enq_ready", 32'(q3.io_enq_ready), 1);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      applyStimulus(3, 0, 0, 0, 0, 1);
      #1;
      checkOutput("tail q3 source", 32'(q3.io_deq_bits_source), 32'(27 + k));
      checkOutput("tail q3 count", 32'(cnt3), 32'(2 - k));
    end
    @(negedge clock);
    applyStimulus(3, 0, 0, 0, 0, 0);
    #1;
    checkOutput("empty q3 deq_valid", 32'(q3.io_deq_valid), 0);

    // DEPTH=2 PIPE=1: enqueue while full succeeds only when the head leaves the same cycle.
    @(negedge clock);
    applyStimulus(2, 1, 0, 0, 30, 0);
    @(negedge clock);
    applyStimulus(2, 1, 0, 0, 31, 0);
    @(negedge clock);
    applyStimulus(2, 1, 0, 0, 9, 0);
    #1;
    checkOutput("pipe q2 ready no deq", 32'(q2.io_enq_ready), 0);
    checkOutput("pipe q2 full count", 32'(cnt2), 2);
    applyStimulus(2, 1, 0, 0, 9, 1);
    #1;
    checkOutput("pipe q2 ready with deq", 32'(q2.io_enq_ready), 1);
    checkOutput("pipe q2 head", 32'(q2.io_deq_bits_source), 30);
    @(negedge clock);
    applyStimulus(2, 0, 0, 0, 0, 1);
    #1;
    checkOutput("pipe q2 count after", 32'(cnt2), 2);
    checkOutput("pipe q2 second", 32'(q2.io_deq_bits_source), 31);
    @(negedge clock);
    #1;
    checkOutput("pipe q2 stored 9", 32'(q2.io_deq_bits_source), 9);
    checkOutput("pipe q2 count 1", 32'(cnt2), 1);
    @(negedge clock);
    applyStimulus(2, 0, 0, 0, 0, 0);
    #1;
    checkOutput("pipe q2 empty", 32'(q2.io_deq_valid), 0);

    // DEPTH=1: alternate enq/deq of every source value; the refused enqueue must not land.
    for (int i = 0; i < 128; i++) begin
      @(negedge clock);
      applyStimulus(1, 1, i, 0, i, 0);
      #1;
      checkOutput("d1 enq_ready empty", 32'(q1.io_enq_ready), 1);
      checkOutput("d1 deq_valid empty", 32'(q1.io_deq_valid), 0);
      @(negedge clock);
      applyStimulus(1, 1, 0, 0, 127 - i, 1);
      #1;
      checkOutput("d1 enq_ready full", 32'(q1.io_enq_ready), 0);
      checkOutput("d1 source", 32'(q1.io_deq_bits_source), 32'(i));
      checkOutput("d1 count", 32'(cnt1), 1);
    end
    @(negedge clock);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("d1 final empty", 32'(q1.io_deq_valid), 0);

    // Empty queue with enq and deq both active: bypass only when the flow feature is built in.
    @(negedge clock);
    applyStimulus(4, 1, 1, 2, 5, 1);
    #1;
`ifdef TL_RESP_QUEUE_FLOW_EN
    checkOutput("flow q4 deq_valid", 32'(q4.io_deq_valid), 1);
    checkOutput("flow q4 source", 32'(q4.io_deq_bits_source), 5);
    checkOutput("flow q4 opcode", 32'(q4.io_deq_bits_opcode), 1);
`else
    checkOutput("noflow q4 deq_valid", 32'(q4.io_deq_valid), 0);
`endif
    @(negedge clock);
    applyStimulus(4, 0, 0, 0, 0, 0);
    #1;
`ifdef TL_RESP_QUEUE_FLOW_EN
    checkOutput("flow q4 count", 32'(cnt4), 0);
    checkOutput("flow q4 not stored", 32'(q4.io_deq_valid), 0);
`else
    checkOutput("noflow q4 count", 32'(cnt4), 1);
    checkOutput("noflow q4 source", 32'(q4.io_deq_bits_source), 5);
    checkOutput("noflow q4 opcode", 32'(q4.io_deq_bits_opcode), 1);
`endif

    // Mid-cycle asynchronous reset discards held entries; the next enqueue lands cleanly.
    @(negedge clock);
    applyStimulus(3, 1, 3, 4, 40, 0);
    @(negedge clock);
    applyStimulus(3, 1, 3, 4, 41, 0);
    @(negedge clock);
    applyStimulus(3, 0, 0, 0, 0, 0);
    #1;
    checkOutput("pre-rst q3 count", 32'(cnt3), 2);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async rst q3 deq_valid", 32'(q3.io_deq_valid), 0);
    checkOutput("async rst q3 enq_ready", 32'(q3.io_enq_ready), 1);
    checkOutput("async rst q3 count", 32'(cnt3), 0);
    checkOutput("async rst q3 source", 32'(q3.io_deq_bits_source), 0);
    checkOutput("async rst q4 count", 32'(cnt4), 0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(3, 1, 6, 5, 42, 0);
    @(negedge clock);
    applyStimulus(3, 0, 0, 0, 0, 0);
    #1;
    checkOutput("post-rst q3 count", 32'(cnt3), 1);
    checkOutput("post-rst q3 source", 32'(q3.io_deq_bits_source), 42);
    checkOutput("post-rst q3 opcode", 32'(q3.io_deq_bits_opcode), 6);
    checkOutput("post-rst q3 size", 32'(q3.io_deq_bits_size), 5);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
